// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data path: accepts one request at a time, accesses
// a word-organised RAM after a fixed wait, and returns a one-cycle ready pulse.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] mem_write,
    input  logic [2:0]  funct3,
    output logic [31:0] mem_read,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Handshake: a request is taken on a rising edge while busy is low and rd_en|wr_en
    // is high; busy then stays high until the edge that ends the single ready cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic          illegal_f3;
    logic          misaligned;
    logic          out_of_range;
    logic          req_err;
    logic [31:0]   load_val;
    logic [3:0]    byte_en;
    logic [31:0]   wlane;
    logic          commit;

    assign word_idx     = addr_q[AW+1:2];
    assign rword        = mem_q[word_idx];
    assign rbyte        = 8'(rword >> {addr_q[1:0], 3'b000});
    assign rhalf        = addr_q[1] ? rword[31:16] : rword[15:0];
    assign misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                          ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign req_err      = illegal_f3 | misaligned | out_of_range;
    // The write happens on the same edge that enters RESP, so a reset during WAIT drops it.
    assign commit       = (state_q == S_WAIT) && (cnt_q == 4'd0) && store_q && !req_err;

    always_comb begin
        illegal_f3 = 1'b1;
        load_val   = 32'd0;
        byte_en    = 4'b0000;
        wlane      = wdata_q;
        case (funct3_q)
            3'b000: begin
                illegal_f3 = 1'b0;
                load_val   = {{24{rbyte[7]}}, rbyte};
                byte_en    = 4'b0001 << addr_q[1:0];
                wlane      = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                illegal_f3 = 1'b0;
                load_val   = {{16{rhalf[15]}}, rhalf};
                byte_en    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane      = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                illegal_f3 = 1'b0;
                load_val   = rword;
                byte_en    = 4'b1111;
            end
            3'b100: begin
                illegal_f3 = store_q;
                load_val   = {24'd0, rbyte};
            end
            3'b101: begin
                illegal_f3 = store_q;
                load_val   = {16'd0, rhalf};
            end
            default: illegal_f3 = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (rd_en || wr_en) begin
                    state_d  = S_WAIT;
                    cnt_d    = 4'(WAIT_STATES);
                    addr_d   = addr;
                    wdata_d  = mem_write;
                    funct3_d = funct3;
                    store_d  = wr_en;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = req_err;
                    if (req_err) begin
                        rdata_d = 32'd0;
                    end else if (!store_q) begin
                        rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            store_q  <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    assign mem_read  = rdata_q;
    assign ready     = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level reference memory, response scoreboard and
// cycle-exact latency/busy checks around every request.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] mem_write = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] mem_read;
    logic        ready;
    logic        busy;
    logic        err;
    logic [1:0]  dbg_state;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .mem_write(mem_write), .funct3(funct3), .mem_read(mem_read),
        .ready(ready), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  ref_mem [int];
    logic [31:0] last_read = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference model; returns {err, mem_read} after the request.
    task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3, output logic [32:0] res);
        int          nb;
        logic        legal, mis, oor, e;
        logic [31:0] v;
        nb    = 1 << f3[1:0];
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
        oor   = (a >= 32'(4 * DEPTH));
        e     = !legal || mis || oor;
        if (e) begin
            last_read = 32'd0;
        end else if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
        end else if (rd) begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
            if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
            last_read = v;
        end
        res = {e, last_read};
    endtask

    // Drives one request, checks busy/ready timing; the response itself is scored by the monitor.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3, input bit poke);
        logic [32:0] r;
        model(rd, wr, a, d, f3, r);
        exp_q.push_back(r);
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; mem_write = d; funct3 = f3;
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            check("wait_busy", {61'd0, busy, ready, err}, 64'b100);
            if (poke) rd_en = (k == 0);
        end
        @(negedge clk);
        check("ready_pulse", {62'd0, busy, ready}, 64'b11);
        @(negedge clk);
        check("after_ready", {61'd0, busy, ready, err}, 64'b000);
    endtask

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 64'(ready), 64'd0);
            end else begin
                check("resp", 64'({err, mem_read}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [32:0] dummy;
        logic [31:0] a;
        repeat (2) @(negedge clk);
        check("reset_outs", {28'd0, mem_read, ready, busy, err, dbg_state}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {61'd0, busy, ready, err}, 64'd0);

        req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
        req(1, 0, 32'h10, 32'h0, 3'b010, 0);
        req(0, 1, 32'h13, 32'h000000A5, 3'b000, 0);
        req(1, 0, 32'h13, 32'h0, 3'b000, 0);
        req(1, 0, 32'h13, 32'h0, 3'b100, 0);
        req(1, 0, 32'h10, 32'h0, 3'b010, 0);
        req(1, 0, 32'h12, 32'h0, 3'b010, 0);
        req(1, 0, 32'h12, 32'h0, 3'b001, 1);
        req(1, 0, 32'h12, 32'h0, 3'b101, 0);
        req(0, 1, 32'h11, 32'h1234, 3'b001, 0);
        req(0, 1, 32'h14, 32'h0, 3'b011, 0);

        // Store aborted by reset while waiting must leave memory untouched.
        req(0, 1, 32'h20, 32'h11111111, 3'b010, 0);
        req(1, 0, 32'h20, 32'h0, 3'b010, 0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b1; addr = 32'h20; mem_write = 32'h22222222; funct3 = 3'b010;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_op", {28'd0, mem_read, ready, busy, err, dbg_state}, 64'd0);
        last_read = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        req(1, 0, 32'h20, 32'h0, 3'b010, 0);

        req(1, 1, 32'h30, 32'h5, 3'b010, 0);
        req(1, 0, 32'h30, 32'h0, 3'b010, 0);
        req(1, 0, 32'(4 * DEPTH), 32'h0, 3'b010, 0);
        req(0, 1, 32'(4 * DEPTH - 4), 32'hCAFEF00D, 3'b010, 0);
        req(1, 0, 32'(4 * DEPTH - 2), 32'h0, 3'b001, 0);

        for (int i = 0; i < 16; i++) req(0, 1, 32'h100 + 32'(4 * i), $urandom, 3'b010, 0);
        for (int i = 0; i < 24; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            req(1, 0, a, 32'h0, 3'($urandom_range(0, 7)), 0);
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            req(0, 1, a, $urandom, 3'($urandom_range(0, 2)), 0);
            req(1, 0, {a[31:2], 2'b00}, 32'h0, 3'b010, 0);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        dummy = 33'd0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
